// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the line-memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE / BUSY / RELEASE)
//   REQ_DCACHE  : requester id of the data cache (port r0)
//   REQ_ICACHE  : requester id of the instruction cache (port r1)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam logic REQ_DCACHE = 1'b0;
  localparam logic REQ_ICACHE = 1'b1;

endpackage

// File: rtl/mem_arb_picker.sv
// mem_arb_picker: 2-way winner selection for mem_arbiter.
//   clk_i    in  system clock
//   rst_i    in  asynchronous reset, active-low
//   req_i    in  request vector, bit N = requester N enable
//   grant_i  in  strobe: the current winner_o is being granted this cycle
//   winner_o out id of the requester that wins now (only meaningful when req_i != 0)
// Build option MEM_ARB_DCACHE_PRIORITY_EN: fixed priority to the dcache, no
// last-grant state. Default: round-robin between the two on a tie.
module mem_arb_picker
  import mem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       grant_i,
  output logic       winner_o
);

`ifdef MEM_ARB_DCACHE_PRIORITY_EN

  always_comb begin
    winner_o = req_i[REQ_DCACHE] ? REQ_DCACHE : REQ_ICACHE;
  end

`else

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    case (req_i)
      2'b01:   winner_o = REQ_DCACHE;
      2'b10:   winner_o = REQ_ICACHE;
      2'b11:   winner_o = ~last_grant_q;
      default: winner_o = REQ_DCACHE;
    endcase
  end

  always_comb begin
    last_grant_d = grant_i ? winner_o : last_grant_q;
  end

  // Resets to the icache id so the dcache wins the first tie.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_grant_q <= REQ_ICACHE;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide memory port between dcache (r0) and icache (r1).
//   clk_i, rst_i                  clock, asynchronous active-low reset
//   r0_enable_i/write_i/addr_i/data_i, r0_ack_o   dcache request port
//   r1_enable_i/addr_i, r1_ack_o                  icache read-only request port
//   rd_data_o                     memory read data to both requesters (qualify with ack)
//   mem_enable_o/write_o/addr_o/data_o            registered memory command
//   mem_data_i, mem_ack_i         memory response
// Build option MEM_ARB_DCACHE_PRIORITY_EN (handled in mem_arb_picker): fixed
// dcache priority instead of round-robin.
//
// state   | meaning
// IDLE    | no transfer; grant the next requester when any enable is high
// BUSY    | command registered to memory, waiting for mem_ack_i
// RELEASE | acked; wait for the granted requester to drop its enable
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              r0_enable_i,
  input  logic              r0_write_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [DATA_W-1:0] r0_data_i,
  output logic              r0_ack_o,
  input  logic              r1_enable_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  output logic              r1_ack_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  arb_state_e        state_q;
  logic              grant_q;
  logic              mem_enable_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;

  logic [1:0]        req;
  logic              winner;
  logic              grant_stb;

  assign req       = {r1_enable_i, r0_enable_i};
  assign grant_stb = (state_q == IDLE) && (req != 2'b00);

  mem_arb_picker u_picker (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req),
    .grant_i  (grant_stb),
    .winner_o (winner)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      grant_q      <= REQ_DCACHE;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_stb) begin
            grant_q      <= winner;
            mem_enable_q <= 1'b1;
            if (winner == REQ_DCACHE) begin
              mem_write_q <= r0_write_i;
              mem_addr_q  <= r0_addr_i;
              mem_data_q  <= r0_data_i;
            end else begin
              mem_write_q <= 1'b0;
              mem_addr_q  <= r1_addr_i;
              mem_data_q  <= '0;
            end
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            state_q      <= RELEASE;
          end
        end
        RELEASE: begin
          // A still-high enable here is the finished request, not a new one.
          if (!req[grant_q]) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign rd_data_o    = mem_data_i;

  assign r0_ack_o = mem_ack_i && (state_q == BUSY) && (grant_q == REQ_DCACHE);
  assign r1_ack_o = mem_ack_i && (state_q == BUSY) && (grant_q == REQ_ICACHE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter.
// Requester tasks push expected commands into per-requester queues; a negedge
// monitor checks every grant against a round-robin/priority model, the held
// memory command, ack routing and returned read data.
module tb_mem_arbiter;

  typedef struct {
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] wdata;
  } txn_t;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         r0_enable_i = 1'b0;
  logic         r0_write_i = 1'b0;
  logic [31:0]  r0_addr_i = '0;
  logic [255:0] r0_data_i = '0;
  logic         r0_ack_o;
  logic         r1_enable_i = 1'b0;
  logic [31:0]  r1_addr_i = '0;
  logic         r1_ack_o;
  logic [255:0] rd_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  txn_t q0[$];
  txn_t q1[$];
  bit   g0 = 1'b0, g1 = 1'b0;    // current transaction of requester N already granted
  bit   owner = 1'b0;
  bit   own_valid = 1'b0;
  bit   last_model = 1'b1;
  logic [1:0] prev_pend = 2'b00;
  bit   prev_men = 1'b0;
  bit   prev_ack = 1'b0;
  bit   mon_on = 1'b0;
  int   fixed_lat = 0;

  mem_arbiter dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .r0_enable_i  (r0_enable_i),
    .r0_write_i   (r0_write_i),
    .r0_addr_i    (r0_addr_i),
    .r0_data_i    (r0_data_i),
    .r0_ack_o     (r0_ack_o),
    .r1_enable_i  (r1_enable_i),
    .r1_addr_i    (r1_addr_i),
    .r1_ack_o     (r1_ack_o),
    .rd_data_o    (rd_data_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mem_word(input logic [31:0] a);
    return {a, ~a, a ^ 32'h1357_9BDF, a + 32'd1, {a[15:0], a[31:16]},
            a ^ 32'hFFFF_0000, a - 32'd7, {16'hC0DE, a[15:0]}};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Arbitration rule: a lone requester wins; on a tie the one not granted last
  // (or always the dcache in the fixed-priority build).
  function automatic bit model_pick(input logic [1:0] pend, input bit last);
    if (pend == 2'b01) return 1'b0;
    if (pend == 2'b10) return 1'b1;
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
    return 1'b0;
`else
    return !last;
`endif
  endfunction

  // Memory model: acks each access once after a random (or forced) latency.
  initial begin
    bit in_acc = 0;
    bit acked = 0;
    int cnt = 0;
    forever begin
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
      if (!rst_i) begin
        in_acc = 0;
        acked  = 0;
      end else if (mem_enable_o && !acked) begin
        if (!in_acc) begin
          in_acc = 1;
          cnt = (fixed_lat > 0) ? fixed_lat - 1 : int'($urandom_range(0, 4));
        end
        if (cnt == 0) begin
          mem_ack_i  = 1'b1;
          mem_data_i = mem_word(mem_addr_o);
          in_acc = 0;
          acked  = 1;
        end else begin
          cnt--;
        end
      end else if (!mem_enable_o) begin
        acked = 0;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk_i) begin
    if (mon_on && rst_i) begin
      if (mem_enable_o && !prev_men) begin
        if (prev_pend == 2'b00) begin
          n_chk++; n_fail++;
          $display("FAIL spurious_grant: memory access at %0t with no pending request, required none", $time);
          own_valid = 1'b0;
        end else begin
          owner = model_pick(prev_pend, last_model);
          own_valid = 1'b1;
          last_model = owner;
          if (owner) g1 = 1'b1; else g0 = 1'b1;
        end
      end
      if (mem_enable_o && own_valid) begin
        if (!owner && q0.size() > 0) begin
          check("cmd_addr_r0", mem_addr_o, q0[0].addr);
          check("cmd_write_r0", mem_write_o, q0[0].wr);
          check("cmd_data_r0", mem_data_o, q0[0].wdata);
        end else if (owner && q1.size() > 0) begin
          check("cmd_addr_r1", mem_addr_o, q1[0].addr);
          check("cmd_write_r1", mem_write_o, 1'b0);
          check("cmd_data_r1", mem_data_o, '0);
        end else begin
          n_chk++; n_fail++;
          $display("FAIL grant_owner: granted req%0d has no outstanding request", owner);
        end
      end
      if (mem_ack_i || r0_ack_o || r1_ack_o) begin
        check("r0_ack_route", r0_ack_o, mem_ack_i && mem_enable_o && own_valid && !owner);
        check("r1_ack_route", r1_ack_o, mem_ack_i && mem_enable_o && own_valid && owner);
      end
      if (r0_ack_o && q0.size() > 0) check("rd_data_r0", rd_data_o, mem_word(q0.pop_front().addr));
      if (r1_ack_o && q1.size() > 0) check("rd_data_r1", rd_data_o, mem_word(q1.pop_front().addr));
      if (prev_ack) begin
        check("enable_drop", mem_enable_o, 1'b0);
        check("write_drop", mem_write_o, 1'b0);
      end
      if (mem_ack_i && mem_enable_o) own_valid = 1'b0;
      prev_pend = {r1_enable_i && !g1, r0_enable_i && !g0};
    end
    prev_men = mem_enable_o;
    prev_ack = mem_ack_i && mem_enable_o;
  end

  task automatic req_txn(input bit id, input bit wr, input logic [31:0] a,
                         input logic [255:0] d, input bit hold, input bit chk_lat);
    txn_t t;
    int   n;
    bit   got;
    @(posedge clk_i); #1;
    t.addr  = a;
    t.wr    = id ? 1'b0 : wr;
    t.wdata = id ? '0 : d;
    if (!id) begin
      g0 = 1'b0; q0.push_back(t);
      r0_write_i = wr; r0_addr_i = a; r0_data_i = d; r0_enable_i = 1'b1;
    end else begin
      g1 = 1'b0; q1.push_back(t);
      r1_addr_i = a; r1_enable_i = 1'b1;
    end
    n = 0;
    got = 0;
    while (!got && n < 300) begin
      @(negedge clk_i);
      if (chk_lat && n == 0) check("lat_not_early", mem_enable_o, 1'b0);
      if (chk_lat && n == 1) check("lat_grant", mem_enable_o, 1'b1);
      got = id ? r1_ack_o : r0_ack_o;
      n++;
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL ack_timeout_req%0d: no ack within %0d cycles, required an ack", id, n);
    end
    if (hold) @(posedge clk_i);
    @(posedge clk_i); #1;
    if (!id) r0_enable_i = 1'b0; else r1_enable_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waitc;
    // Reset state, with a memory ack present that must not reach either requester.
    #2 mem_ack_i = 1'b1;
    #10;
    check("rst_mem_enable", mem_enable_o, 1'b0);
    check("rst_mem_write", mem_write_o, 1'b0);
    check("rst_mem_addr", mem_addr_o, '0);
    check("rst_mem_data", mem_data_o, '0);
    check("rst_r0_ack", r0_ack_o, 1'b0);
    check("rst_r1_ack", r1_ack_o, 1'b0);
    mem_ack_i = 1'b0;
    #10 rst_i = 1'b1;
    mon_on = 1'b1;

    // Single dcache read, memory acks after 5 cycles.
    fixed_lat = 5;
    req_txn(0, 0, 32'h0000_0040, rand256(), 0, 1);
    fixed_lat = 0;

    // Simultaneous requests, repeatedly.
    fork
      for (int i = 0; i < 4; i++) req_txn(0, 0, 32'h0000_0100 + 32'(i * 32), rand256(), 0, 0);
      for (int i = 0; i < 4; i++) req_txn(1, 0, 32'h0000_2000 + 32'(i * 32), '0, 0, 0);
    join

    // Write-back followed by a read.
    fixed_lat = 3;
    req_txn(0, 1, 32'h0000_0420, {32{8'hA5}}, 0, 0);
    req_txn(0, 0, 32'h0000_0040, rand256(), 0, 0);
    fixed_lat = 0;

    // Enable held one cycle past ack.
    req_txn(0, 0, 32'h0000_0060, rand256(), 1, 0);
    req_txn(1, 0, 32'h0000_3000, '0, 1, 0);

    // Spurious ack in IDLE, then a request must still see single-cycle latency.
    repeat (2) @(posedge clk_i);
    #2 mem_ack_i = 1'b1; mem_data_i = rand256();
    @(posedge clk_i); #2 mem_ack_i = 1'b0;
    req_txn(0, 0, 32'h0000_0080, rand256(), 0, 1);

    // Randomized traffic from both requesters.
    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk_i);
        req_txn(0, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFE0, rand256(),
                1'($urandom_range(0, 1)), 0);
      end
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk_i);
        req_txn(1, 0, $urandom & 32'hFFFF_FFE0, '0, 1'($urandom_range(0, 1)), 0);
      end
    join

    // Reset asserted mid-transfer.
    fixed_lat = 50;
    @(posedge clk_i); #1;
    mon_on = 1'b0;
    r0_write_i = 1'b1; r0_addr_i = 32'h0000_0500; r0_data_i = rand256(); r0_enable_i = 1'b1;
    waitc = 0;
    while (!mem_enable_o && waitc < 20) begin
      @(negedge clk_i);
      waitc++;
    end
    check("busy_before_reset", mem_enable_o, 1'b1);
    @(posedge clk_i); #3;
    rst_i = 1'b0;
    r0_enable_i = 1'b0;
    #1;
    check("async_rst_enable", mem_enable_o, 1'b0);
    check("async_rst_write", mem_write_o, 1'b0);
    check("async_rst_addr", mem_addr_o, '0);
    check("async_rst_data", mem_data_o, '0);
    check("async_rst_r0_ack", r0_ack_o, 1'b0);
    check("async_rst_r1_ack", r1_ack_o, 1'b0);
    q0.delete(); q1.delete();
    g0 = 1'b0; g1 = 1'b0; own_valid = 1'b0; last_model = 1'b1; prev_pend = 2'b00;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    fixed_lat = 0;
    mon_on = 1'b1;
    req_txn(1, 0, 32'h0000_1000, '0, 0, 1);
    // After reset the dcache must win the first tie again.
    fork
      req_txn(0, 0, 32'h0000_0200, rand256(), 0, 0);
      req_txn(1, 0, 32'h0000_4000, '0, 0, 0);
    join

    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    check("q0_drained", 256'(q0.size()), '0);
    check("q1_drained", 256'(q1.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
